fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter sharing one synchronous FIFO write port among `NUM_REQ` producers. It sits directly in front of the FIFO (`FIFO_WIDTH`=16, `FIFO_DEPTH`=8). It tracks free FIFO slots with an internal credit counter, so it never issues a write that would overflow. It flags any FIFO overflow or credit inconsistency as a sticky error.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `FIFO_WIDTH`, default 16: data width.
- `FIFO_DEPTH`, default 8: FIFO entries; credit counter width is `$clog2(FIFO_DEPTH+1)`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester write request; must hold until its `gnt` bit is seen.
- `req_data`  in  NUM_REQ*FIFO_WIDTH  packed data; requester i occupies slice [i*W +: W]; stable while `req[i]`=1.
- `gnt`  out  NUM_REQ  registered one-hot grant pulse; item of requester i has been taken.
- `fifo_wr_en`  out  1  registered write strobe to FIFO.
- `fifo_data_in`  out  FIFO_WIDTH  registered write data.
- `fifo_rd_pop`  in  1  successful FIFO read this cycle (`rd_en && !empty`, formed by the consumer).
- `fifo_overflow`  in  1  FIFO overflow flag.
- `credits`  out  $clog2(FIFO_DEPTH+1)  free slots as seen by the arbiter.
- `stall`  out  1  state is STALL.
- `err`  out  1  sticky error; cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: no eligible request.
  - ACTIVE: a grant is issued this cycle.
  - STALL: requests pending, `credits`==0.
- State is a registered next-state computed each cycle from eligible requests and credits.
- Eligible: `req[i]`=1 and `gnt[i]`=0. A requester granted last cycle is masked for one cycle, so the same item is never taken twice.
- Arbitration:
  - Search starts at `rr_ptr`, wraps modulo NUM_REQ, and picks the first eligible requester.
  - On issue, `rr_ptr` <= winner+1 (wrap to 0 after NUM_REQ-1).
- Issue condition: an eligible requester exists and `credits`>0.
  - A `fifo_rd_pop` in the same cycle does not make issue legal at `credits`==0; the check is conservative.
- Credit update each cycle: `credits` <= `credits` - issue + `fifo_rd_pop`.
  - Simultaneous issue and pop leave `credits` unchanged.
  - Pop while `credits`==FIFO_DEPTH: `credits` saturates at FIFO_DEPTH and `err` <= 1.
- Error: `fifo_overflow`=1 in any cycle also sets `err` <= 1.

## Timing
- Reset values: `gnt`=0, `fifo_wr_en`=0, `fifo_data_in`=0, `credits`=FIFO_DEPTH, `stall`=0, `err`=0, `rr_ptr`=0, state IDLE.
- Latency: arbitration in cycle t gives `gnt[i]`=1, `fifo_wr_en`=1 and `fifo_data_in`=`req_data[i]` (sampled at t) in cycle t+1.
  - `gnt` and `fifo_wr_en` are high for exactly one cycle per issue.
- `credits` reflects the issue one cycle after arbitration, i.e. together with `fifo_wr_en`.
- Throughput: one write per cycle when at least 2 requesters are active. A lone requester gets at most one grant every 2 cycles because of the masking rule.
- Requester rule: after seeing `gnt[i]`, present the next item (or drop `req`) in the same cycle. The arbiter re-samples it one cycle later.
- `stall` is registered and asserts the cycle after `credits` reaches 0 with requests pending. It clears the cycle after the first pop.
- Reset mid-operation: every output returns to its reset value on the next edge. No pending grant is delivered. The FIFO must be reset in the same cycle so that its occupancy matches `credits`.

## Structure
- Shared package `fifo_arb_pkg`: state enum (`IDLE`, `ACTIVE`, `STALL`), `FIFO_WIDTH`/`FIFO_DEPTH` defaults, credit width constant.
- Sub-module `rr_pick`: combinational rotate-priority encoder (inputs: eligible mask, `rr_ptr`; outputs: one-hot winner, valid).
- Top level holds the FSM, credit counter, output registers and error logic.

## Test plan
- Reset then idle, `req`=0: `credits`=8, `gnt`=0, `fifo_wr_en`=0, `err`=0 for 10 cycles.
- All 4 requesters held high with data 0xA0..0xA3, consumer popping every cycle: grants 0,1,2,3,0,… in consecutive cycles. Each `fifo_data_in` matches its requester, and `credits` stays at 8 minus at most 1 in flight.
- Single requester 2 holding `req` with data incrementing per grant, no pops: `gnt[2]` every 2nd cycle for 8 items, then `credits`=0 and `stall`=1. No further grant and `fifo_overflow` never asserts.
- From `stall`=1 with `credits`=0, one pop: `credits`=1, `stall` clears, exactly one grant issues, then `credits`=0 again.
- Issue and pop in the same cycle at `credits`=5: `credits` stays 5. Pop at `credits`=8: `credits` stays 8 and `err`=1 until `rst`.
- `rst` asserted in the cycle after arbitration: no `gnt` or `fifo_wr_en` pulse, `credits`=8, `rr_ptr` restarts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and default sizes for the FIFO write-side arbiter.
// Holds the FSM state encoding, the default FIFO geometry and the credit
// counter width that matches that default geometry.
package fifo_arb_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  // Counter must hold the value DEPTH itself (empty FIFO), hence DEPTH+1.
  localparam int CREDIT_W       = $clog2(DEF_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles the requester handshake, the FIFO write port and
// the arbiter status lines.
//   req / req_data       : requester requests and packed per-requester data
//   gnt                  : one-hot grant pulse back to the requesters
//   fifo_wr_en/_data_in  : write strobe and data towards the FIFO
//   fifo_rd_pop          : successful FIFO read (from the consumer)
//   fifo_overflow        : FIFO overflow flag
//   credits / stall / err: arbiter status
// master = arbiter side, slave = environment (requesters, FIFO, consumer).
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_rd_pop;
  logic                          fifo_overflow;
  logic [CNT_W-1:0]              credits;
  logic                          stall;
  logic                          err;

  modport master (
    input  req, req_data, fifo_rd_pop, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in, credits, stall, err
  );

  modport slave (
    output req, req_data, fifo_rd_pop, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in, credits, stall, err
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   elig  : eligible requester mask
//   ptr   : index where the search starts (wraps modulo N)
//   win   : one-hot winner (all zero when nothing is eligible)
//   valid : at least one requester is eligible
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             valid
);

  logic [PTR_W-1:0] idx_s;
  logic             hit_s;

  // Walk the requesters starting at ptr; the first eligible one wins.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx_s = ptr;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s      = PTR_W'((int'(ptr) + k) % N);
      hit_s      = !valid && elig[idx_s];
      win[idx_s] = win[idx_s] | hit_s;
      valid      = valid | hit_s;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. A credit counter mirrors the free FIFO slots so a write
// is only issued when a slot is guaranteed; overflow or credit inconsistency
// sets a sticky error.
//   clk, rst : clock and synchronous active-high reset
//   bus      : requester handshake, FIFO write port and status (master side)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_REQ     = PTR_W'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        credits_q, credits_d;
  logic                    err_q, err_d;

  logic [NUM_REQ-1:0]      elig_s;
  logic [NUM_REQ-1:0]      win_s;
  logic                    pick_valid_s;
  logic                    issue_s;
  logic                    stall_cond_s;
  logic [PTR_W-1:0]        win_idx_s;
  logic [FIFO_WIDTH-1:0]   sel_data_s;

  // The requester granted last cycle has not yet replaced its item, so mask it.
  assign elig_s  = bus.req & ~gnt_q;
  // Conservative: a pop in this cycle never makes an issue legal at zero credits.
  assign issue_s = pick_valid_s && (credits_q != {CNT_W{1'b0}});

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .elig  (elig_s),
    .ptr   (rr_ptr_q),
    .win   (win_s),
    .valid (pick_valid_s)
  );

  // Convert the one-hot winner into an index and select its data slice.
  always_comb begin
    win_idx_s  = {PTR_W{1'b0}};
    sel_data_s = {FIFO_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      win_idx_s  = win_idx_s | (win_s[k] ? PTR_W'(k) : {PTR_W{1'b0}});
      sel_data_s = sel_data_s |
                   (win_s[k] ? bus.req_data[k*FIFO_WIDTH +: FIFO_WIDTH] : {FIFO_WIDTH{1'b0}});
    end
  end

  // Next-state, credit, pointer, output and error computation.
  always_comb begin
    credits_d = credits_q;
    case ({issue_s, bus.fifo_rd_pop})
      2'b10:   credits_d = credits_q - CNT_W'(1);
      // A pop with all credits home means the FIFO was empty: saturate.
      2'b01:   credits_d = (credits_q == FULL_CREDITS) ? credits_q : credits_q + CNT_W'(1);
      default: credits_d = credits_q;
    endcase

    // Stall is judged on the credits that will be visible next cycle, so a
    // pop lifts it immediately and stall=1 always coincides with credits=0.
    stall_cond_s = (|elig_s) && (credits_d == {CNT_W{1'b0}});
    case ({issue_s, stall_cond_s})
      2'b10, 2'b11: state_d = ACTIVE;
      2'b01:        state_d = STALL;
      default:      state_d = IDLE;
    endcase

    if (issue_s) begin
      rr_ptr_d = (win_idx_s == LAST_REQ) ? {PTR_W{1'b0}} : win_idx_s + PTR_W'(1);
      data_d   = sel_data_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
      data_d   = data_q;
    end
    gnt_d   = issue_s ? win_s : {NUM_REQ{1'b0}};
    wr_en_d = issue_s;

    err_d = err_q | bus.fifo_overflow |
            (bus.fifo_rd_pop && (credits_q == FULL_CREDITS));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= {PTR_W{1'b0}};
      gnt_q     <= {NUM_REQ{1'b0}};
      wr_en_q   <= 1'b0;
      data_q    <= {FIFO_WIDTH{1'b0}};
      credits_q <= FULL_CREDITS;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.credits      = credits_q;
  assign bus.stall        = (state_q == STALL);
  assign bus.err          = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter.
// A requester model serves item lists, a behavioural FIFO occupancy model
// drives pops/overflow, expected writes are queued by the directed sequence
// and a negedge monitor pops and compares every write it observes.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 8;

  typedef struct {
    int          id;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   n_wr  = 0;
  int   cyc   = 0;
  int   wr_cyc_q[$];
  exp_t exp_q[$];
  exp_t e;
  bit   chk_inv = 1'b0;

  // Requester model: main owns target/base/incr, the model owns granted.
  int   target[N];
  int   base_cnt[N];
  int   base_val[N];
  bit   incr[N];
  int   granted[N];

  // FIFO occupancy model.
  int   occ = 0;
  logic ovf_r = 1'b0;
  bit   auto_pop = 1'b0;
  bit   force_pop = 1'b0;

  assign bus.fifo_rd_pop   = (auto_pop && (occ != 0)) || force_pop;
  assign bus.fifo_overflow = ovf_r;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      occ   <= 0;
      ovf_r <= 1'b0;
    end else begin
      occ   <= occ + (bus.fifo_wr_en ? 1 : 0) - ((bus.fifo_rd_pop && (occ != 0)) ? 1 : 0);
      ovf_r <= bus.fifo_wr_en && (occ == D) && !bus.fifo_rd_pop;
    end
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) granted[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) granted[i] = granted[i] + 1;
        bus.req[i] = (granted[i] < target[i]);
        bus.req_data[i*W +: W] = W'(base_val[i] + (incr[i] ? (granted[i] - base_cnt[i]) : 0));
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.fifo_wr_en) begin
        n_wr++;
        wr_cyc_q.push_back(cyc);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write gnt=%b data=%h", bus.gnt, bus.fifo_data_in);
        end else begin
          e = exp_q.pop_front();
          if (bus.gnt !== (4'b0001 << e.id) || bus.fifo_data_in !== e.data) begin
            n_err++;
            $display("FAIL write gnt=%b data=%h required gnt=%b data=%h",
                     bus.gnt, bus.fifo_data_in, 4'b0001 << e.id, e.data);
          end
        end
      end else if (bus.gnt !== 4'b0000) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_gnt gnt=%b required 0000", bus.gnt);
      end
      if (chk_inv) begin
        n_vec++;
        if (32'(bus.credits) !== 32'(D - occ - (bus.fifo_wr_en ? 1 : 0))) begin
          n_err++;
          $display("FAIL credit_track credits=%0d required=%0d", bus.credits,
                   D - occ - (bus.fifo_wr_en ? 1 : 0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_wr(input int tgt, input int budget);
    int k;
    k = 0;
    while (n_wr < tgt && k < budget) begin
      step();
      k++;
    end
    check("wait_write", (n_wr >= tgt) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic set_req(input int i, input int cnt, input int val, input bit inc);
    base_cnt[i] = granted[i];
    base_val[i] = val;
    incr[i]     = inc;
    target[i]   = granted[i] + cnt;
  endtask

  task automatic push_exp(input int id, input int val);
    exp_t x;
    x.id   = id;
    x.data = W'(val);
    exp_q.push_back(x);
  endtask

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      target[i] = 0; base_cnt[i] = 0; base_val[i] = 0; incr[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_inv = 1'b1;

    // Reset then idle.
    check("rst_data", 32'(bus.fifo_data_in), 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_credits", 32'(bus.credits), 32'd8);
      check("idle_gnt", 32'(bus.gnt), 32'd0);
      check("idle_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      check("idle_err", 32'(bus.err), 32'd0);
      check("idle_stall", 32'(bus.stall), 32'd0);
    end

    // All four requesters, consumer popping whenever the FIFO holds data.
    auto_pop = 1'b1;
    wr_cyc_q.delete();
    base = n_wr;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_exp(i, 16'h00A0 + i);
    for (int i = 0; i < N; i++) set_req(i, 3, 16'h00A0 + i, 1'b0);
    wait_wr(base + 12, 60);
    check("rr_back_to_back", 32'(wr_cyc_q[11] - wr_cyc_q[0]), 32'd11);
    repeat (6) step();
    check("drain_credits", 32'(bus.credits), 32'd8);
    check("drain_err", 32'(bus.err), 32'd0);
    auto_pop = 1'b0;

    // Lone requester 2, incrementing data, no pops: fills all 8 credits.
    wr_cyc_q.delete();
    base = n_wr;
    for (int k = 0; k < 8; k++) push_exp(2, 16'h0200 + k);
    set_req(2, 10, 16'h0200, 1'b1);
    wait_wr(base + 8, 40);
    check("lone_count", 32'(wr_cyc_q.size()), 32'd8);
    for (int k = 1; k < wr_cyc_q.size(); k++)
      check("lone_spacing", 32'(wr_cyc_q[k] - wr_cyc_q[k-1]), 32'd2);
    repeat (6) step();
    check("full_credits", 32'(bus.credits), 32'd0);
    check("full_stall", 32'(bus.stall), 32'd1);
    check("full_no_grant", 32'(n_wr), 32'(base + 8));
    check("full_no_err", 32'(bus.err), 32'd0);

    // One pop out of stall: exactly one more grant.
    push_exp(2, 16'h0208);
    force_pop = 1'b1;
    step();
    force_pop = 1'b0;
    check("pop_credits", 32'(bus.credits), 32'd1);
    check("pop_stall_clear", 32'(bus.stall), 32'd0);
    step();
    check("pop_one_grant", 32'(n_wr), 32'(base + 9));
    check("pop_credits_zero", 32'(bus.credits), 32'd0);
    repeat (4) step();
    check("restall", 32'(bus.stall), 32'd1);
    check("restall_no_grant", 32'(n_wr), 32'(base + 9));
    check("restall_no_err", 32'(bus.err), 32'd0);
    target[2] = granted[2];

    // Simultaneous issue and pop at credits 5.
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("sb_empty_1", 32'(exp_q.size()), 32'd0);
    check("rst2_credits", 32'(bus.credits), 32'd8);
    check("rst2_err", 32'(bus.err), 32'd0);
    check("rst2_stall", 32'(bus.stall), 32'd0);
    base = n_wr;
    for (int k = 0; k < 3; k++) push_exp(0, 16'h0300 + k);
    set_req(0, 3, 16'h0300, 1'b1);
    wait_wr(base + 3, 30);
    repeat (2) step();
    check("five_credits", 32'(bus.credits), 32'd5);
    push_exp(1, 16'h0310);
    set_req(1, 1, 16'h0310, 1'b0);
    step();
    force_pop = 1'b1;
    step();
    force_pop = 1'b0;
    check("issue_pop_write", 32'(n_wr), 32'(base + 4));
    check("issue_pop_credits", 32'(bus.credits), 32'd5);
    repeat (3) step();
    check("issue_pop_hold", 32'(bus.credits), 32'd5);

    // Pop with all credits home: saturate and sticky error.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    force_pop = 1'b1;
    step();
    force_pop = 1'b0;
    check("sat_credits", 32'(bus.credits), 32'd8);
    check("sat_err", 32'(bus.err), 32'd1);
    repeat (3) step();
    check("sticky_err", 32'(bus.err), 32'd1);
    check("sticky_credits", 32'(bus.credits), 32'd8);
    rst = 1'b1;
    step();
    check("err_cleared", 32'(bus.err), 32'd0);
    rst = 1'b0;

    // Reset right after arbitration: pending grant dropped, pointer restarts.
    step();
    base = n_wr;
    push_exp(0, 16'h0400);
    set_req(0, 2, 16'h0400, 1'b1);
    set_req(1, 1, 16'h0410, 1'b0);
    wait_wr(base + 1, 20);
    rst = 1'b1;
    push_exp(0, 16'h0401);
    push_exp(1, 16'h0410);
    step();
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("midrst_credits", 32'(bus.credits), 32'd8);
    rst = 1'b0;
    wait_wr(base + 3, 20);
    repeat (3) step();
    check("sb_empty_2", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
